divrem_iter: RTL and testbench
==============================

// Module: divrem_iter
// PURPOSE
//  Iterative radix-2 restoring divider/remainder unit for the RV32M DIV/DIVU/REM/REMU path.
//  Sits directly under the execute-stage mult/div block: consumes dividend/divider/signed and a start pulse.
//  Returns quotient and remainder with a busy flag and a one-cycle done pulse, as the execute stall logic expects.
//  One quotient bit per clock; results are held until the next start.
// PARAMETERS
//  XLEN     32  operand/result width
//  CNT_W    5   iteration counter width, = $clog2(XLEN)
// PORTS
//  clk           in   1     clock, rising edge
//  cpurst        in   1     reset, asynchronous, active-high
//  dividend      in   XLEN  rs1 operand, sampled only on diven_p
//  divider       in   XLEN  rs2 operand, sampled only on diven_p
//  divsigned     in   1     1 = DIV/REM semantics, 0 = DIVU/REMU; sampled on diven_p
//  diven_p       in   1     start pulse; honoured only in IDLE
//  quo           out  XLEN  quotient, registered, held after done
//  rem           out  XLEN  remainder, registered, held after done
//  diven         out  1     busy: high in CALC and FIXUP
//  divout_valid  out  1     one-cycle done pulse; quo/rem are valid in that cycle
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; quo=0, rem=0, diven=0, divout_valid=0; counter and working regs cleared.
//  States: IDLE -> CALC -> FIXUP -> DONE -> IDLE.
//  IDLE: on diven_p, latch the operands.
//   - signed: a = |dividend|, b = |divider|; qneg = sd^sv; rneg = sd (sd/sv = operand sign bits).
//   - unsigned: a, b taken raw; qneg = rneg = 0.
//   - dz = (divider==0). Clear partial remainder and counter; go to CALC.
//  CALC: XLEN cycles. Each cycle: r' = {r[XLEN-2:0], a[MSB]}, a <<= 1.
//   - If r' >= b: r = r'-b, shift in quotient bit 1; else r = r', shift in 0.
//   - After iteration XLEN-1 (counter==XLEN-1), go to FIXUP.
//  FIXUP: one cycle; load quo/rem.
//   - dz: quo = all-ones, rem = original dividend (raw).
//   - else: quo = qneg ? -q : q; rem = rneg ? -r : r.
//   - Overflow 0x80000000 / 0xFFFFFFFF (signed) falls out naturally: quo = 0x80000000, rem = 0.
//  DONE: divout_valid=1 for exactly one cycle, diven=0; then IDLE.
//  Latency: diven_p high in cycle 0 -> diven high cycles 1..XLEN+1 -> divout_valid in cycle XLEN+2 (34).
//  diven_p in CALC/FIXUP/DONE is ignored; operands are not re-sampled.
//  Caller gating: the caller gates diven_p with !diven & !divout_valid. A diven_p in the DONE cycle is still ignored.
//  quo/rem change only in FIXUP and on reset; they are stable from DONE until the next FIXUP.
//  Subtraction is XLEN+1 bits wide to keep the borrow; all negation is two's complement modulo 2^XLEN.
// CONFIGURATION
//  DIVREM_EARLY_OUT_EN defined: in IDLE on diven_p, if !dz and a < b (unsigned, post-abs):
//   - skip CALC; q=0, r=a; go straight to FIXUP (sign fixup still applied);
//   - divout_valid in cycle 3 (diven high cycles 1..2).
//  DIVREM_EARLY_OUT_EN undefined: every operation takes the full XLEN iterations (fixed 34-cycle latency).
// STRUCTURE
//  Package divrem_pkg:
//   - state enum (IDLE, CALC, FIXUP, DONE);
//   - XLEN default;
//   - constants DIVZ_QUO = all-ones and SIGNED_MIN = 0x80000000.
//  Sub-module divrem_step: combinational single restoring iteration (r, a, b -> r_next, a_next, qbit).
//  FSM, counter and sign fixup stay in divrem_iter.
// TESTING
//  1. DIVU 100/7 -> divout_valid cycle 34, quo=14, rem=2; diven high cycles 1..33 only.
//  2. DIV 0xFFFFFFF9(-7)/2 -> quo=0xFFFFFFFD, rem=0xFFFFFFFF; REM 7/0xFFFFFFFE -> quo=0xFFFFFFFD, rem=1.
//  3. Divide-by-zero: DIV 0x12345678/0 and DIVU 0x80000000/0 -> quo=0xFFFFFFFF, rem=dividend.
//  4. DIV 0x80000000/0xFFFFFFFF -> quo=0x80000000, rem=0, no hang; result held until next start.
//  5. diven_p re-pulsed at cycle 5 with different operands -> ignored, original result at cycle 34.
//     cpurst at cycle 10 -> outputs 0 immediately, IDLE; a new start then completes normally.
//  6. DIVU 5/9:
//     - macro on: quo=0, rem=5, divout_valid at cycle 3;
//     - macro off: same values at cycle 34.

Source files
------------

// File: rtl/divrem_pkg.sv
// divrem_pkg: shared widths, FSM state type and result constants for the iterative divider
package divrem_pkg;
    localparam int XLEN = 32;
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] DIVZ_QUO = '1;
    localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
endpackage

// File: rtl/divrem_if.sv
// divrem_if: operand/start and result/status bundle between execute stage and divider
interface divrem_if;
    import divrem_pkg::*;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divider;
    logic divsigned;
    logic diven_p;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;
    logic diven;
    logic divout_valid;
    modport master (output dividend, divider, divsigned, diven_p, input quo, rem, diven, divout_valid);
    modport slave (input dividend, divider, divsigned, diven_p, output quo, rem, diven, divout_valid);
endinterface

// File: rtl/divrem_step.sv
// divrem_step: one restoring iteration; the shifted remainder keeps its carry bit so divisors near 2^XLEN stay exact
module divrem_step
    import divrem_pkg::*;
(
    input  logic [XLEN-1:0] r,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] r_next,
    output logic [XLEN-1:0] a_next,
    output logic qbit
);
    logic [XLEN:0] r_sh;
    // shift in the next dividend bit, subtract when it fits, and push the quotient bit into a's lsb
    always_comb begin
        r_sh = {r, a[XLEN-1]};
        qbit = r_sh >= {1'b0, b};
        r_next = qbit ? r_sh[XLEN-1:0] - b : r_sh[XLEN-1:0];
        a_next = {a[XLEN-2:0], qbit};
    end
endmodule

// File: rtl/divrem_iter.sv
// divrem_iter: radix-2 restoring DIV/DIVU/REM/REMU unit; DIVREM_EARLY_OUT_EN skips iteration when |dividend| < |divider|
module divrem_iter
    import divrem_pkg::*;
(
    input logic clk,
    input logic cpurst,
    divrem_if.slave io
);
    state_t state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] r, a, b, dvd, quo, rem, r_next, a_next;
    logic qneg, rneg, dz, qbit, early, last;
    divrem_step u_step (.r(r), .a(a), .b(b), .r_next(r_next), .a_next(a_next), .qbit(qbit));
`ifdef DIVREM_EARLY_OUT_EN
    assign early = state == CALC && cnt == '0 && !dz && a < b;
`else
    assign early = 1'b0;
`endif
    assign last = cnt == CNT_W'(XLEN - 1);
    assign io.quo = quo;
    assign io.rem = rem;
    // state register
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) state <= IDLE;
        else state <= state_next;
    end
    // next-state: start only from IDLE, leave CALC after the last iteration or on early out
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = io.diven_p ? CALC : IDLE;
            CALC:    state_next = (early || last) ? FIXUP : CALC;
            FIXUP:   state_next = DONE;
            default: state_next = IDLE;
        endcase
    end
    // status outputs decoded from state
    always_comb begin
        io.diven = state == CALC || state == FIXUP;
        io.divout_valid = state == DONE;
    end
    // datapath: latch magnitudes in IDLE, iterate in CALC (a ends up holding q), apply signs in FIXUP
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            {r, a, b, dvd, quo, rem} <= '0;
            {qneg, rneg, dz} <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (io.diven_p) begin
                    a <= (io.divsigned && io.dividend[XLEN-1]) ? -io.dividend : io.dividend;
                    b <= (io.divsigned && io.divider[XLEN-1]) ? -io.divider : io.divider;
                    qneg <= io.divsigned && (io.dividend[XLEN-1] ^ io.divider[XLEN-1]);
                    rneg <= io.divsigned && io.dividend[XLEN-1];
                    dz <= io.divider == '0;
                    dvd <= io.dividend;
                    r <= '0;
                    cnt <= '0;
                end
                CALC: begin
                    r <= early ? a : r_next;
                    a <= early ? '0 : a_next;
                    cnt <= cnt + CNT_W'(1);
                end
                FIXUP: begin
                    quo <= dz ? DIVZ_QUO : qneg ? -a : a;
                    rem <= dz ? dvd : rneg ? -r : r;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_divrem_iter.sv
// tb_divrem_iter: directed vectors for divrem_iter covering latency, signs, divide-by-zero, overflow, re-start and reset
module tb_divrem_iter;
    import divrem_pkg::*;
    logic clk = 1'b0;
    logic cpurst = 1'b1;
    int total = 0;
    int bad = 0;
`ifdef DIVREM_EARLY_OUT_EN
    localparam int LAT_E = 3;
`else
    localparam int LAT_E = 34;
`endif
    divrem_if bus ();
    divrem_iter dut (.clk(clk), .cpurst(cpurst), .io(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // called on a negedge (cycle 0); poke>0 re-pulses diven_p with other operands in that cycle
    task automatic run(input string tag, input logic s, input logic [31:0] x, input logic [31:0] y,
                       input int lat, input logic [31:0] eq, input logic [31:0] er, input int poke);
        int got, busy;
        bus.dividend = x;
        bus.divider = y;
        bus.divsigned = s;
        bus.diven_p = 1'b1;
        @(negedge clk);
        bus.diven_p = 1'b0;
        got = 0;
        busy = 0;
        for (int k = 1; k <= 40; k++) begin
            if (bus.divout_valid) begin
                got = k;
                break;
            end
            if (bus.diven) busy++;
            if (k == poke) begin
                bus.dividend = 32'd1000;
                bus.divider = 32'd3;
                bus.divsigned = 1'b0;
                bus.diven_p = 1'b1;
            end else bus.diven_p = 1'b0;
            @(negedge clk);
        end
        bus.diven_p = 1'b0;
        chk({tag, " latency"}, got, lat);
        chk({tag, " busy_cycles"}, busy, lat - 1);
        chk({tag, " diven_at_done"}, {31'b0, bus.diven}, 32'd0);
        chk({tag, " quo"}, bus.quo, eq);
        chk({tag, " rem"}, bus.rem, er);
        @(negedge clk);
        chk({tag, " valid_one_cycle"}, {31'b0, bus.divout_valid}, 32'd0);
        chk({tag, " quo_held"}, bus.quo, eq);
    endtask

    initial begin
        bus.dividend = '0;
        bus.divider = '0;
        bus.divsigned = 1'b0;
        bus.diven_p = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset quo", bus.quo, 32'd0);
        chk("reset rem", bus.rem, 32'd0);
        chk("reset busy", {31'b0, bus.diven}, 32'd0);
        chk("reset valid", {31'b0, bus.divout_valid}, 32'd0);
        cpurst = 1'b0;
        @(negedge clk);
        run("divu_100_7", 1'b0, 32'd100, 32'd7, 34, 32'd14, 32'd2, 0);
        run("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
        run("rem_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 34, 32'hFFFF_FFFD, 32'd1, 0);
        run("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 34, 32'd14, 32'hFFFF_FFFE, 0);
        run("div_dz", 1'b1, 32'h1234_5678, 32'd0, 34, 32'hFFFF_FFFF, 32'h1234_5678, 0);
        run("divu_dz", 1'b0, 32'h8000_0000, 32'd0, 34, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run("div_ovf", 1'b1, SIGNED_MIN, 32'hFFFF_FFFF, 34, 32'h8000_0000, 32'd0, 0);
        repeat (5) @(negedge clk);
        chk("ovf quo_still_held", bus.quo, 32'h8000_0000);
        chk("ovf rem_still_held", bus.rem, 32'd0);
        run("divu_big", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 32'd1, 32'd1, 0);
        run("restart_ignored", 1'b0, 32'd100, 32'd7, 34, 32'd14, 32'd2, 5);
        bus.dividend = 32'hFFFF_FFFF;
        bus.divider = 32'd3;
        bus.divsigned = 1'b0;
        bus.diven_p = 1'b1;
        @(negedge clk);
        bus.diven_p = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_reset busy", {31'b0, bus.diven}, 32'd1);
        cpurst = 1'b1;
        #1;
        chk("async_reset quo", bus.quo, 32'd0);
        chk("async_reset rem", bus.rem, 32'd0);
        chk("async_reset busy", {31'b0, bus.diven}, 32'd0);
        chk("async_reset valid", {31'b0, bus.divout_valid}, 32'd0);
        @(negedge clk);
        cpurst = 1'b0;
        @(negedge clk);
        run("after_reset", 1'b0, 32'd100, 32'd7, 34, 32'd14, 32'd2, 0);
        run("divu_5_9", 1'b0, 32'd5, 32'd9, LAT_E, 32'd0, 32'd5, 0);
        run("divu_small_big", 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, LAT_E, 32'd0, 32'hFFFF_FFFE, 0);
        run("div_m5_9", 1'b1, 32'hFFFF_FFFB, 32'd9, LAT_E, 32'd0, 32'hFFFF_FFFB, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
